// File: rtl/photo_readout_sm_if.sv
// photo_readout_sm_if: frame-buffer read port plus valid/ready pixel stream.
//   rd_en/rd_addr/rd_data : synchronous BRAM read port (1-cycle latency)
//   pix_data/pix_valid/pix_ready/pix_last : pixel stream towards host/DMA
//   master modport: readout engine; slave modport: BRAM model + pixel consumer
interface photo_readout_sm_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  modport master (output rd_en, rd_addr, pix_data, pix_valid, pix_last, input rd_data, pix_ready);
  modport slave (input rd_en, rd_addr, pix_data, pix_valid, pix_last, output rd_data, pix_ready);
endinterface

// File: rtl/photo_readout_sm.sv
// photo_readout_sm: drains one frame from the frame-buffer read port onto a valid/ready pixel stream.
//   clk, reset (async active-low), start (sampled in IDLE), ack (sampled in DONE)
//   busy (READ/DRAIN), done (DONE), error (sticky, ERROR), checksum (16-bit frame sum)
//   bus : photo_readout_sm_if.master carrying the BRAM read port and the pixel stream
//   Optional macro PHOTO_READOUT_CHKSUM_EN enables the checksum accumulator; otherwise checksum is 0.
module photo_readout_sm #(
  parameter int NUM_PIXELS = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] checksum,
  photo_readout_sm_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, DRAIN = 3'd2, DONE = 3'd3, ERROR = 3'd4} state_e;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
  logic [2:0]        state;
  logic              rd_en, rvalid, last_taken;
  logic [ADDR_W-1:0] rd_addr, pix_idx;
  logic [DATA_W-1:0] f0, f1;
  logic [1:0]        cnt, cnt_nx;
  logic              pix_valid, pix_last, accept, push, pop;
  // The word returning from BRAM this cycle (rvalid) is the FIFO's fall-through
  // entry: it is presented immediately when the FIFO is empty, which gives the
  // 2-cycle start-to-valid latency and 1 pixel/clk with pix_ready held high.
  assign pix_valid = busy & ((cnt != 2'd0) | rvalid);
  assign accept = pix_valid & bus.pix_ready;
  assign pop = accept & (cnt != 2'd0);
  assign push = rvalid & ~(accept & (cnt == 2'd0));
  assign cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
  assign pix_last = pix_valid & (pix_idx == LAST);
  assign bus.rd_en = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_last = pix_last;
  assign bus.pix_data = !pix_valid ? '0 : (cnt != 2'd0 ? f0 : bus.rd_data);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rd_en <= 1'b0;
      rd_addr <= '0;
      rvalid <= 1'b0;
      cnt <= 2'd0;
      f0 <= '0;
      f1 <= '0;
      pix_idx <= '0;
      last_taken <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      rvalid <= rd_en;
      cnt <= cnt_nx;
      if (pop) f0 <= f1;
      // a pushed word lands in the slot just past the post-pop occupancy
      if (push) begin
        if (cnt_nx == 2'd1) f0 <= bus.rd_data;
        else f1 <= bus.rd_data;
      end
      if (accept) pix_idx <= pix_idx + ADDR_W'(1);
      case (state)
        IDLE: if (start) begin
          state <= READ;
          busy <= 1'b1;
          rd_en <= 1'b1;
          rd_addr <= '0;
          pix_idx <= '0;
        end
        READ: begin
          if (rd_en && rd_addr == LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            // next-cycle occupancy is the buffered words plus the read in flight now
            rd_en <= (cnt_nx + {1'b0, rd_en}) < 2'd2;
            if (rd_en) rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (accept && pix_last) last_taken <= 1'b1;
          if (last_taken) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            last_taken <= 1'b0;
          end
        end
        DONE: if (ack) begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: begin
          state <= ERROR;
          error <= 1'b1;
          busy <= 1'b0;
          done <= 1'b0;
          rd_en <= 1'b0;
          rd_addr <= '0;
          rvalid <= 1'b0;
          cnt <= 2'd0;
          last_taken <= 1'b0;
        end
      endcase
    end
  end
`ifdef PHOTO_READOUT_CHKSUM_EN
  logic [15:0] csum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum <= '0;
    else if (state == IDLE && start) csum <= '0;
    else if (accept) csum <= csum + 16'(bus.pix_data);
  end
  assign checksum = error ? '0 : csum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_photo_readout_sm.sv
// tb_photo_readout_sm: randomized self-checking bench for photo_readout_sm against a frame-level model.
module tb_photo_readout_sm;
  localparam int N = 4, AW = 2, DW = 12;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, ack = 1'b0;
  logic busy, done, error;
  logic [15:0] checksum;
  logic [DW-1:0] mem [N];
  int compared = 0, mismatched = 0;
  photo_readout_sm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  photo_readout_sm #(.NUM_PIXELS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .busy(busy), .done(done),
    .error(error), .checksum(checksum), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  // Runs one frame from a start pulse until done; the model is the frame itself:
  // pixels mem[0..N-1] in order, last on N-1, reads at addresses 0..N-1 with at most
  // two words outstanding (issued - accepted), stable data while stalled.
  task automatic run_frame(input int mode, input bit hold_start, output int first_cyc,
                           output int last_cyc, output int done_cyc, output logic [31:0] rd_mask);
    int issued = 0, acc = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [15:0] sum = '0, exp_sum;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; rd_mask = '0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      if (!hold_start) start = 1'b0;
      bus.pix_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'((c - 1) % 3 == 0) :
                      mode == 3 ? 1'(c > 10) : 1'($urandom_range(0, 1));
      if (bus.rd_en === 1'b1) begin
        compared++;
        if (issued - acc >= 2 || int'(bus.rd_addr) != issued) begin
          mismatched++;
          $display("FAIL read_issue cycle %0d: addr=%0d outstanding=%0d, required addr=%0d outstanding<2",
                   c, bus.rd_addr, issued - acc, issued);
        end
        issued++;
        if (c < 32) rd_mask[c] = 1'b1;
      end
      if (stalled) begin
        compared++;
        if (bus.pix_valid !== 1'b1 || bus.pix_data !== held) begin
          mismatched++;
          $display("FAIL stall_hold cycle %0d: valid=%b data=%h, required valid=1 data=%h",
                   c, bus.pix_valid, bus.pix_data, held);
        end
      end
      if (bus.pix_valid === 1'b1 && bus.pix_ready) begin
        compared++;
        if (acc >= N || bus.pix_data !== mem[acc] || bus.pix_last !== 1'(acc == N - 1)) begin
          mismatched++;
          $display("FAIL pixel %0d cycle %0d: data=%h last=%b, required data=%h last=%b",
                   acc, c, bus.pix_data, bus.pix_last, acc < N ? mem[acc] : '0, acc == N - 1);
        end
        if (first_cyc < 0) first_cyc = c;
        if (bus.pix_last === 1'b1) last_cyc = c;
        acc++;
      end
      stalled = bus.pix_valid === 1'b1 && !bus.pix_ready;
      held = bus.pix_data;
      if (done === 1'b1) done_cyc = c;
      else @(negedge clk);
    end
    compared++;
    if (done_cyc < 0 || acc != N || issued != N || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_end: done_cyc=%0d pixels=%0d reads=%0d busy=%b, required done pixels=%0d reads=%0d busy=0",
               done_cyc, acc, issued, busy, N, N);
    end
    for (int i = 0; i < N; i++) sum = sum + 16'(mem[i]);
`ifdef PHOTO_READOUT_CHKSUM_EN
    exp_sum = sum;
`else
    exp_sum = '0;
`endif
    compared++;
    if (checksum !== exp_sum) begin
      mismatched++;
      $display("FAIL checksum: got %h, required %h", checksum, exp_sum);
    end
  endtask
  task automatic finish_frame(input int wait_cycles, input bit with_start);
    for (int i = 0; i < wait_cycles; i++) begin
      start = with_start;
      @(negedge clk);
      compared++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL done_hold: done=%b busy=%b, required done=1 busy=0", done, busy);
      end
    end
    start = with_start;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_idle: done=%b busy=%b, required done=0 busy=0", done, busy);
    end
  endtask
  task automatic test_reset();
    bus.pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, done, error, bus.rd_en, bus.pix_valid, bus.pix_last} !== 6'b0 ||
        bus.rd_addr !== '0 || bus.pix_data !== '0 || checksum !== '0) begin
      mismatched++;
      $display("FAIL reset_values: busy=%b done=%b error=%b rd_en=%b valid=%b last=%b addr=%0d data=%h sum=%h, required all 0",
               busy, done, error, bus.rd_en, bus.pix_valid, bus.pix_last, bus.rd_addr, bus.pix_data, checksum);
    end
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask
  task automatic test_basic();
    int f, l, d;
    logic [31:0] m;
    for (int i = 0; i < N; i++) mem[i] = DW'(12'h100 + i);
    run_frame(0, 1'b0, f, l, d, m);
    compared++;
    if (f != 2 || l != 5 || d != 7 || m != 32'b11110) begin
      mismatched++;
      $display("FAIL basic_timing: first=%0d last=%0d done=%0d rd_mask=%b, required 2 5 7 11110", f, l, d, m);
    end
    finish_frame(1, 1'b0);
  endtask
  task automatic test_stall();
    int f, l, d;
    logic [31:0] m;
    for (int i = 0; i < N; i++) mem[i] = DW'(12'h100 + i);
    run_frame(1, 1'b0, f, l, d, m);
    finish_frame(0, 1'b0);
    run_frame(3, 1'b0, f, l, d, m);
    finish_frame(2, 1'b0);
  endtask
  task automatic test_ignore();
    int f, l, d;
    logic [31:0] m;
    for (int i = 0; i < N; i++) mem[i] = DW'(12'h100 + i);
    run_frame(0, 1'b1, f, l, d, m);
    finish_frame(2, 1'b1);
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.rd_en !== 1'b0) begin
      mismatched++;
      $display("FAIL no_restart: busy=%b done=%b rd_en=%b, required 0 0 0", busy, done, bus.rd_en);
    end
    run_frame(2, 1'b0, f, l, d, m);
    finish_frame(0, 1'b0);
  endtask
  task automatic test_abort();
    int f, l, d;
    logic [31:0] m;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 4095));
    bus.pix_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.pix_data !== mem[2] || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_pre: data=%h busy=%b, required data=%h busy=1", bus.pix_data, busy, mem[2]);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, error, bus.rd_en, bus.pix_valid, bus.pix_last} !== 6'b0 ||
        bus.rd_addr !== '0 || bus.pix_data !== '0 || checksum !== '0) begin
      mismatched++;
      $display("FAIL abort_async: busy=%b done=%b rd_en=%b valid=%b addr=%0d data=%h, required all 0",
               busy, done, bus.rd_en, bus.pix_valid, bus.rd_addr, bus.pix_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
    run_frame(0, 1'b0, f, l, d, m);
    finish_frame(0, 1'b0);
  endtask
  task automatic test_checksum();
    int f, l, d;
    logic [31:0] m;
    logic [15:0] want;
    for (int i = 0; i < N; i++) mem[i] = 12'hFFF;
    run_frame(0, 1'b0, f, l, d, m);
`ifdef PHOTO_READOUT_CHKSUM_EN
    want = 16'h3FFC;
`else
    want = 16'h0000;
`endif
    compared++;
    if (checksum !== want) begin
      mismatched++;
      $display("FAIL checksum_fff: got %h, required %h", checksum, want);
    end
    finish_frame(1, 1'b0);
  endtask
  task automatic test_random();
    int f, l, d;
    logic [31:0] m;
    repeat (15) begin
      for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 4095));
      run_frame(2, 1'($urandom_range(0, 1)), f, l, d, m);
      finish_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic test_error();
    @(negedge clk);
    force dut.state = 3'd7;
    #1 release dut.state;
    @(negedge clk);
    compared++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.rd_en !== 1'b0 ||
        bus.pix_valid !== 1'b0 || checksum !== '0) begin
      mismatched++;
      $display("FAIL error_entry: error=%b busy=%b done=%b rd_en=%b valid=%b sum=%h, required 1 0 0 0 0 0",
               error, busy, done, bus.rd_en, bus.pix_valid, checksum);
    end
    start = 1'b1;
    ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL error_sticky: error=%b busy=%b done=%b, required 1 0 0", error, busy, done);
      end
    end
    start = 1'b0;
    ack = 1'b0;
    reset = 1'b0;
    #1;
    compared++;
    if (error !== 1'b0) begin
      mismatched++;
      $display("FAIL error_reset: error=%b, required 0", error);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ignore();
    test_abort();
    test_checksum();
    test_random();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
